// File: rtl/pipe_pkg.sv
// Shared widths and ID/EX control-bundle field positions for the MIPS pipeline registers.
package pipe_pkg;

    localparam int PIPE_CTRL_W = 10;
    localparam int PIPE_DATA_W = 111;

    localparam logic [31:0] WORD_ZERO = 32'h0000_0000;

    // Bit positions of the ID/EX control bundle; ALU_op occupies the top four bits.
    localparam int MEM_WRITE_BIT  = 0;
    localparam int MEM_READ_BIT   = 1;
    localparam int REG_WRITE_BIT  = 2;
    localparam int REG_DST_BIT    = 3;
    localparam int MEM_TO_REG_BIT = 4;
    localparam int ALU_SRC_BIT    = 5;
    localparam int ALU_OP_LSB     = 6;
    localparam int ALU_OP_W       = 4;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready bus carrying one pipeline entry (control bundle + data bundle).
interface pipe_stage_reg_if import pipe_pkg::*; #(
    parameter int CTRL_W = PIPE_CTRL_W,
    parameter int DATA_W = PIPE_DATA_W
);
    logic              valid;
    logic              ready;
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;

    modport master (output valid, output ctrl, output data, input ready);
    modport slave  (input valid, input ctrl, input data, output ready);
endinterface

// File: rtl/pipe_slot.sv
// One storage slot of a pipeline register: valid flag plus control and data bundles.
module pipe_slot import pipe_pkg::*; #(
    parameter int CTRL_W = PIPE_CTRL_W,
    parameter int DATA_W = PIPE_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              load,
    input  logic              clear_valid,
    input  logic [CTRL_W-1:0] d_ctrl,
    input  logic [DATA_W-1:0] d_data,
    output logic              q_valid,
    output logic [CTRL_W-1:0] q_ctrl,
    output logic [DATA_W-1:0] q_data
);

    // Slot register: flush squashes valid and ctrl but keeps data so no X reaches the bus.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_valid <= 1'b0;
            q_ctrl  <= {CTRL_W{1'b0}};
            q_data  <= {DATA_W{1'b0}};
        end else if (flush) begin
            q_valid <= 1'b0;
            q_ctrl  <= {CTRL_W{1'b0}};
        end else if (load) begin
            q_valid <= 1'b1;
            q_ctrl  <= d_ctrl;
            q_data  <= d_data;
        end else if (clear_valid) begin
            q_valid <= 1'b0;
        end else begin
            q_valid <= q_valid;
        end
    end

endmodule

// File: rtl/pipe_stage_reg_chk.sv
// Structural invariants of pipe_stage_reg.
module pipe_stage_reg_chk #(
    parameter int CTRL_W = 10
) (
    input logic              clk,
    input logic              rst,
    input logic              m_valid,
    input logic              s_valid,
    input logic              out_valid,
    input logic [CTRL_W-1:0] out_ctrl
);

    a_skid_implies_main: assert property (@(posedge clk) disable iff (rst) s_valid |-> m_valid);

    a_bubble_ctrl_zero: assert property (@(posedge clk) disable iff (rst)
        !out_valid |-> (out_ctrl == {CTRL_W{1'b0}}));

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register with optional skid slot, flush, bubble masking
// and a saturating stall-cycle counter.
module pipe_stage_reg import pipe_pkg::*; #(
    parameter int CTRL_W = PIPE_CTRL_W,
    parameter int DATA_W = PIPE_DATA_W,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    pipe_stage_reg_if.slave         up,
    pipe_stage_reg_if.master        dn,
    output logic [1:0]              occ,
    output logic [CNT_W-1:0]        stall_cnt
);

    logic              in_fire_s, out_fire_s;
    logic              m_load_s, m_clr_s, m_sel_skid_s, s_load_s, s_clr_s;
    logic              m_valid_s, s_valid_s;
    logic [CTRL_W-1:0] m_ctrl_s, s_ctrl_s, m_d_ctrl_s;
    logic [DATA_W-1:0] m_data_s, s_data_s, m_d_data_s;
    logic [CNT_W-1:0]  stall_cnt_r;

    assign in_fire_s  = up.valid & up.ready;
    assign out_fire_s = m_valid_s & dn.ready;

    // Slot steering: the skid entry always drains into M before new input, keeping FIFO order.
    always_comb begin
        m_load_s     = 1'b0;
        m_clr_s      = 1'b0;
        m_sel_skid_s = 1'b0;
        s_load_s     = 1'b0;
        s_clr_s      = 1'b0;
        if (SKID == 1) begin
            if (out_fire_s) begin
                if (s_valid_s) begin
                    m_load_s     = 1'b1;
                    m_sel_skid_s = 1'b1;
                    s_clr_s      = 1'b1;
                end else if (in_fire_s) begin
                    m_load_s = 1'b1;
                end else begin
                    m_clr_s = 1'b1;
                end
            end else if (!m_valid_s) begin
                m_load_s = in_fire_s;
            end else begin
                s_load_s = in_fire_s;
            end
        end else begin
            if (in_fire_s) begin
                m_load_s = 1'b1;
            end else begin
                m_clr_s = out_fire_s;
            end
        end
    end

    assign m_d_ctrl_s = m_sel_skid_s ? s_ctrl_s : up.ctrl;
    assign m_d_data_s = m_sel_skid_s ? s_data_s : up.data;

    pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .load        (m_load_s),
        .clear_valid (m_clr_s),
        .d_ctrl      (m_d_ctrl_s),
        .d_data      (m_d_data_s),
        .q_valid     (m_valid_s),
        .q_ctrl      (m_ctrl_s),
        .q_data      (m_data_s)
    );

    generate
        if (SKID == 1) begin : g_skid
            pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
                .clk         (clk),
                .rst         (rst),
                .flush       (flush),
                .load        (s_load_s),
                .clear_valid (s_clr_s),
                .d_ctrl      (up.ctrl),
                .d_data      (up.data),
                .q_valid     (s_valid_s),
                .q_ctrl      (s_ctrl_s),
                .q_data      (s_data_s)
            );
            // Ready comes straight from a flop, so out_ready never reaches in_ready.
            assign up.ready = ~s_valid_s;
        end else begin : g_noskid
            assign s_valid_s = 1'b0;
            assign s_ctrl_s  = {CTRL_W{1'b0}};
            assign s_data_s  = {DATA_W{1'b0}};
            assign up.ready  = ~m_valid_s | dn.ready;
        end
    endgenerate

    assign dn.valid = m_valid_s;
    assign dn.ctrl  = m_valid_s ? m_ctrl_s : {CTRL_W{1'b0}};
    assign dn.data  = m_data_s;
    assign occ      = {1'b0, m_valid_s} + {1'b0, s_valid_s};

    // Stall-cycle counter: counts held-but-not-taken cycles, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (m_valid_s && !dn.ready && !flush && (stall_cnt_r != {CNT_W{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stall_cnt = stall_cnt_r;

    pipe_stage_reg_chk #(.CTRL_W(CTRL_W)) u_chk (
        .clk       (clk),
        .rst       (rst),
        .m_valid   (m_valid_s),
        .s_valid   (s_valid_s),
        .out_valid (dn.valid),
        .out_ctrl  (dn.ctrl)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: skid instance (CNT_W=4) plus a single-entry instance.
module tb_pipe_stage_reg;

    localparam int CW = 10;
    localparam int DW = 111;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    logic [1:0] occ_a, occ_b;
    logic [3:0] stall_a;
    logic [15:0] stall_b;
    int checks = 0;
    int errors = 0;

    pipe_stage_reg_if #(.CTRL_W(CW), .DATA_W(DW)) ua ();
    pipe_stage_reg_if #(.CTRL_W(CW), .DATA_W(DW)) da ();
    pipe_stage_reg_if #(.CTRL_W(CW), .DATA_W(DW)) ub ();
    pipe_stage_reg_if #(.CTRL_W(CW), .DATA_W(DW)) db ();

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1), .CNT_W(4)) u_a (
        .clk(clk), .rst(rst), .flush(flush), .up(ua), .dn(da), .occ(occ_a), .stall_cnt(stall_a));

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(0), .CNT_W(16)) u_b (
        .clk(clk), .rst(rst), .flush(flush), .up(ub), .dn(db), .occ(occ_b), .stall_cnt(stall_b));

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_a(input logic [CW-1:0] c, input logic [DW-1:0] d);
        ua.valid = 1'b1;
        ua.ctrl  = c;
        ua.data  = d;
        tick();
        ua.valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        da.ready = 1'b0;
        push_a(10'h0A1, 111'd11);
        push_a(10'h0A2, 111'd12);
        checks++;
        if (occ_a !== 2'd2) begin $display("FAIL reset_prefill_occ: got %0d expected 2", occ_a); errors++; end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (occ_a !== 2'd0) begin $display("FAIL reset_occ: got %0d expected 0", occ_a); errors++; end
        checks++;
        if (da.valid !== 1'b0 || da.ctrl !== 10'h000) begin
            $display("FAIL reset_out: valid %b ctrl %h expected 0 000", da.valid, da.ctrl); errors++;
        end
        checks++;
        if (da.data !== 111'd0) begin $display("FAIL reset_data: got %h expected 0", da.data); errors++; end
        checks++;
        if (stall_a !== 4'd0 || ua.ready !== 1'b1) begin
            $display("FAIL reset_cnt_ready: stall %0d ready %b expected 0 1", stall_a, ua.ready); errors++;
        end
    endtask

    task automatic test_streaming;
        da.ready = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            ua.valid = 1'b1;
            ua.ctrl  = 10'(i);
            ua.data  = 111'(i);
            checks++;
            if (ua.ready !== 1'b1) begin $display("FAIL stream_ready_%0d: got %b expected 1", i, ua.ready); errors++; end
            tick();
            checks++;
            if (da.valid !== 1'b1 || da.ctrl !== 10'(i) || da.data !== 111'(i)) begin
                $display("FAIL stream_out_%0d: valid %b ctrl %h data %0d expected 1 %h %0d",
                         i, da.valid, da.ctrl, da.data, 10'(i), i);
                errors++;
            end
        end
        ua.valid = 1'b0;
        tick();
        checks++;
        if (da.valid !== 1'b0 || stall_a !== 4'd0) begin
            $display("FAIL stream_drain: valid %b stall %0d expected 0 0", da.valid, stall_a); errors++;
        end
    endtask

    task automatic test_skid_fill;
        da.ready = 1'b0;
        push_a(10'h0AA, 111'hA);
        push_a(10'h0BB, 111'hB);
        checks++;
        if (occ_a !== 2'd2 || ua.ready !== 1'b0 || da.ctrl !== 10'h0AA) begin
            $display("FAIL skid_full: occ %0d ready %b ctrl %h expected 2 0 0aa", occ_a, ua.ready, da.ctrl); errors++;
        end
        da.ready = 1'b1;
        tick();
        checks++;
        if (da.valid !== 1'b1 || da.ctrl !== 10'h0BB || da.data !== 111'hB || occ_a !== 2'd1) begin
            $display("FAIL skid_second: valid %b ctrl %h occ %0d expected 1 0bb 1", da.valid, da.ctrl, occ_a); errors++;
        end
        tick();
        checks++;
        if (da.valid !== 1'b0 || occ_a !== 2'd0 || ua.ready !== 1'b1) begin
            $display("FAIL skid_empty: valid %b occ %0d ready %b expected 0 0 1", da.valid, occ_a, ua.ready); errors++;
        end
    endtask

    task automatic test_flush;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        da.ready = 1'b0;
        push_a(10'h011, 111'h11);
        push_a(10'h022, 111'h22);
        ua.valid = 1'b1;
        ua.ctrl  = 10'h0CC;
        ua.data  = 111'hCC;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        ua.valid = 1'b0;
        checks++;
        if (occ_a !== 2'd0 || da.valid !== 1'b0 || da.ctrl !== 10'h000) begin
            $display("FAIL flush_full: occ %0d valid %b ctrl %h expected 0 0 000", occ_a, da.valid, da.ctrl); errors++;
        end
        checks++;
        if (da.data !== 111'h11 || stall_a !== 4'd1) begin
            $display("FAIL flush_hold: data %h stall %0d expected 11 1", da.data, stall_a); errors++;
        end
        // Collision with a ready stage: C really would be accepted without the flush.
        push_a(10'h033, 111'h33);
        ua.valid = 1'b1;
        ua.ctrl  = 10'h0CC;
        ua.data  = 111'hCC;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        ua.valid = 1'b0;
        checks++;
        if (occ_a !== 2'd0 || da.valid !== 1'b0) begin
            $display("FAIL flush_collide: occ %0d valid %b expected 0 0", occ_a, da.valid); errors++;
        end
        da.ready = 1'b1;
        push_a(10'h0DD, 111'hDD);
        checks++;
        if (da.valid !== 1'b1 || da.ctrl !== 10'h0DD || da.data !== 111'hDD) begin
            $display("FAIL flush_next: valid %b ctrl %h expected 1 0dd", da.valid, da.ctrl); errors++;
        end
        tick();
        checks++;
        if (da.valid !== 1'b0 || occ_a !== 2'd0) begin
            $display("FAIL flush_after: valid %b occ %0d expected 0 0", da.valid, occ_a); errors++;
        end
    endtask

    task automatic test_bubble;
        ua.valid = 1'b0;
        ua.ctrl  = 10'h3FF;
        ua.data  = {DW{1'b1}};
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (da.valid !== 1'b0 || da.ctrl !== 10'h000 || da.data !== 111'hDD) begin
                $display("FAIL bubble_%0d: valid %b ctrl %h data %h expected 0 000 dd", i, da.valid, da.ctrl, da.data);
                errors++;
            end
        end
    endtask

    task automatic test_skid0;
        db.ready = 1'b0;
        ub.valid = 1'b1;
        ub.ctrl  = 10'h155;
        ub.data  = 111'h55;
        checks++;
        if (ub.ready !== 1'b1) begin $display("FAIL s0_empty_ready: got %b expected 1", ub.ready); errors++; end
        tick();
        ub.valid = 1'b0;
        tick();
        checks++;
        if (db.valid !== 1'b1 || db.ctrl !== 10'h155 || occ_b !== 2'd1 || stall_b !== 16'd1) begin
            $display("FAIL s0_hold: valid %b ctrl %h occ %0d stall %0d expected 1 155 1 1",
                     db.valid, db.ctrl, occ_b, stall_b);
            errors++;
        end
        ub.valid = 1'b1;
        ub.ctrl  = 10'h2AA;
        ub.data  = 111'hAA;
        #1;
        checks++;
        if (ub.ready !== 1'b0) begin $display("FAIL s0_full_ready: got %b expected 0", ub.ready); errors++; end
        db.ready = 1'b1;
        #1;
        checks++;
        if (ub.ready !== 1'b1) begin $display("FAIL s0_pass_ready: got %b expected 1", ub.ready); errors++; end
        tick();
        ub.valid = 1'b0;
        checks++;
        if (db.ctrl !== 10'h2AA || db.data !== 111'hAA || occ_b !== 2'd1) begin
            $display("FAIL s0_replace: ctrl %h occ %0d expected 2aa 1", db.ctrl, occ_b); errors++;
        end
        tick();
        checks++;
        if (db.valid !== 1'b0 || occ_b !== 2'd0 || db.ctrl !== 10'h000) begin
            $display("FAIL s0_drain: valid %b occ %0d ctrl %h expected 0 0 000", db.valid, occ_b, db.ctrl); errors++;
        end
    endtask

    task automatic test_stall_sat;
        logic [3:0] exp_cnt;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        da.ready = 1'b0;
        push_a(10'h0EE, 111'hEE);
        for (int i = 1; i <= 20; i++) begin
            tick();
            exp_cnt = (i >= 15) ? 4'd15 : 4'(i);
            checks++;
            if (stall_a !== exp_cnt) begin
                $display("FAIL stall_cnt_%0d: got %0d expected %0d", i, stall_a, exp_cnt); errors++;
            end
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if (stall_a !== 4'd15 || da.valid !== 1'b0) begin
            $display("FAIL stall_flush: stall %0d valid %b expected 15 0", stall_a, da.valid); errors++;
        end
    endtask

    initial begin
        ua.valid = 1'b0; ua.ctrl = 10'h000; ua.data = 111'd0; da.ready = 1'b0;
        ub.valid = 1'b0; ub.ctrl = 10'h000; ub.data = 111'd0; db.ready = 1'b0;
        test_reset();
        test_streaming();
        test_skid_fill();
        test_flush();
        test_bubble();
        test_skid0();
        test_stall_sat();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
